seg7_scan_driver: RTL and testbench

//  Downstream display stage for the game core. Takes four hex nibbles plus per-digit enables
//  and time-multiplexes them onto the 4-digit common-anode 7-seg display (an/seg, active-low).

---
 rtl/seg7_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-seg driver with frame-synchronous double buffering
// and a one-cycle blank between digits. Optional blinking is enabled with `define SEG7_BLINK_EN.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  digit_en,
    input  logic        load,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
    logic [3:0]    pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic          pend_valid_q, pend_valid_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          fd_q, fd_d;
    logic          tick, boundary, lit;
    logic [3:0]    nib, dark;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;  4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;  4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;  4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;  4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;  4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;  4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;  4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;  default: decode = 7'b0001110;
        endcase
    endfunction

`ifdef SEG7_BLINK_EN
    logic [31:0] fcnt_q;
    logic        phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (boundary) begin
            if (fcnt_q == 32'(BLINK_FRAMES - 1)) begin
                fcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                fcnt_q <= fcnt_q + 32'd1;
            end
        end
    end

    // Mask is live so the game core can start/stop blinking without a reload.
    assign dark = blink_mask & {4{phase_q}};
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic [3:0] unused_blink_mask;
    assign unused_blink_mask = blink_mask;
    assign dark = 4'b0000;
`endif

    assign tick     = (presc_q == PW'(REFRESH_DIV - 1));
    assign boundary = tick && (idx_q == 2'd3);
    assign nib      = act_dig_q[{idx_q, 2'b00} +: 4];
    assign lit      = act_en_q[idx_q] && !dark[idx_q];

    always_comb begin
        presc_d      = tick ? '0 : presc_q + PW'(1);
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        pend_dig_d   = load ? digits_in : pend_dig_q;
        pend_en_d    = load ? digit_en : pend_en_q;
        pend_valid_d = pend_valid_q || load;
        act_dig_d    = act_dig_q;
        act_en_d     = act_en_q;
        // A load coinciding with the boundary bypasses pending and commits directly.
        if (boundary && load) begin
            act_dig_d    = digits_in;
            act_en_d     = digit_en;
            pend_valid_d = 1'b0;
        end else if (boundary && pend_valid_q) begin
            act_dig_d    = pend_dig_q;
            act_en_d     = pend_en_q;
            pend_valid_d = 1'b0;
        end
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if (!tick && lit) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode(nib);
        end
        fd_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            pend_dig_q   <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            act_dig_q    <= '0;
            act_en_q     <= '0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            fd_q         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            act_dig_q    <= act_dig_d;
            act_en_q     <= act_en_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            fd_q         <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: each frame's expected an/seg sequence is queued and
// popped cycle-by-cycle starting at the frame_done pulse.
module tb_seg7_scan_driver;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;
    logic        load;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int nframes;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(DIV), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .digit_en(digit_en), .load(load),
        .blink_mask(blink_mask), .an(an), .seg(seg), .frame_done(frame_done)
    );

    // Frame boundaries seen since the last reset.
    always @(posedge clk or posedge rst) begin
        if (rst) nframes <= 0;
        else if (frame_done) nframes <= nframes + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Called at the negedge of a frame_done cycle; checks all 16 cycles of that frame and
    // optionally drives a one-cycle load at frame cycle ld_at.
    task automatic run_frame(input logic [15:0] d, input logic [3:0] en, input int ld_at,
                             input logic [15:0] ld_d, input logic [3:0] ld_en);
        exp_t e;
        exp_t g;
        logic [3:0] dark;
        logic [3:0] sel;
`ifdef SEG7_BLINK_EN
        logic ph;
        ph   = (((nframes + 1) / 2) % 2) == 1;
        dark = blink_mask & {4{ph}};
`else
        dark = 4'b0000;
`endif
        g.an  = 4'b1111;
        g.seg = 7'b1111111;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(g);
            sel   = 4'b0001 << k;
            e.an  = ~sel;
            e.seg = hex7(d[4*k +: 4]);
            for (int r = 0; r < DIV - 1; r++)
                sb.push_back((en[k] && !dark[k]) ? e : g);
        end
        for (int i = 0; i < 4 * DIV; i++) begin
            if (i > 0) @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("an[c%0d,d%0h]", i, d), 32'(an), 32'(e.an));
            chk($sformatf("seg[c%0d,d%0h]", i, d), 32'(seg), 32'(e.seg));
            chk($sformatf("fd[c%0d]", i), 32'(frame_done), (i == 0) ? 32'd1 : 32'd0);
            if (i == ld_at) begin
                digits_in = ld_d;
                digit_en  = ld_en;
                load      = 1'b1;
            end else if (i == ld_at + 1) begin
                load = 1'b0;
            end
        end
    endtask

    task automatic next_frame();
        @(negedge clk);
        chk("frame_done", 32'(frame_done), 32'd1);
    endtask

    // Bounded wait for the first frame_done after reset release; counts negedges.
    task automatic wait_first_fd(input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            load = 1'b0;
        end while (!frame_done && n < 100);
        chk("fd_latency", 32'(n), 32'(exp_n));
    endtask

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        digits_in  = '0;
        digit_en   = '0;
        blink_mask = 4'b0001;
        #12;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_fd", 32'(frame_done), 32'd0);

        @(negedge clk);
        digits_in = 16'h1234;
        digit_en  = 4'b1111;
        load      = 1'b1;
        rst       = 1'b0;
        wait_first_fd(4 * DIV);

        run_frame(16'h1234, 4'b1111, 5, 16'hABCD, 4'b1111);
        next_frame();
        run_frame(16'hABCD, 4'b1111, 15, 16'h00F0, 4'b1111);
        next_frame();
        run_frame(16'h00F0, 4'b1111, 0, 16'h0000, 4'b1111);
        next_frame();
        run_frame(16'h0000, 4'b1111, 3, 16'h1234, 4'b0101);
        next_frame();
        run_frame(16'h1234, 4'b0101, -1, 16'h0, 4'b0);
        next_frame();
        run_frame(16'h1234, 4'b0101, -1, 16'h0, 4'b0);

        // Reset while digit 2 is being driven.
        next_frame();
        repeat (10) @(negedge clk);
        chk("mid_an", 32'(an), 32'hB);
        chk("mid_seg", 32'(seg), 32'(hex7(4'h2)));
        #2 rst = 1'b1;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_first_fd(4 * DIV);
        run_frame(16'h0000, 4'b0000, -1, 16'h0, 4'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
